// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared constants and state encoding
// for the serial EEPROM responder.
package eeprom_pkg;

  localparam logic [3:0] DEV_ID_DEF = 4'b1010;
  localparam int         RW_BIT     = 0;
  localparam logic       ACK_LVL    = 1'b0;
  localparam logic       NACK_LVL   = 1'b1;

  typedef enum logic [9:0] {
    S_IDLE      = 10'b00_0000_0001,
    S_CTRL      = 10'b00_0000_0010,
    S_ACK_CTRL  = 10'b00_0000_0100,
    S_ADDR      = 10'b00_0000_1000,
    S_ACK_ADDR  = 10'b00_0001_0000,
    S_WDATA     = 10'b00_0010_0000,
    S_ACK_WDATA = 10'b00_0100_0000,
    S_RDATA     = 10'b00_1000_0000,
    S_RACK      = 10'b01_0000_0000,
    S_WAIT_STOP = 10'b10_0000_0000
  } state_t;

endpackage

// File: rtl/eeprom_line_sync.sv
// eeprom_line_sync: SCL/SDA synchronizers and
// registered rise/fall/start/stop strobes.
module eeprom_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_rise,
  output logic o_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_s;
  logic [1:0] r_sda_s;
  logic       r_scl_p;
  logic       r_sda_p;
  logic       r_rise;
  logic       r_fall;
  logic       r_start;
  logic       r_stop;

  // reset to an idle (high) bus so no event fires on release
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_p <= 1'b1;
      r_sda_p <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_scl_s <= {r_scl_s[0], i_scl};
      r_sda_s <= {r_sda_s[0], i_sda};
      r_scl_p <= r_scl_s[1];
      r_sda_p <= r_sda_s[1];
      r_rise  <= r_scl_s[1] & ~r_scl_p;
      r_fall  <= ~r_scl_s[1] & r_scl_p;
      r_start <= r_scl_s[1] & r_scl_p
               & ~r_sda_s[1] & r_sda_p;
      r_stop  <= r_scl_s[1] & r_scl_p
               & r_sda_s[1] & ~r_sda_p;
    end
  end

  assign o_sda   = r_sda_p;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_start = r_start;
  assign o_stop  = r_stop;

endmodule

// File: rtl/eeprom_rsp.sv
// eeprom_rsp: serial EEPROM responder with an
// internal 2^AW x 8 memory and open-drain SDA.
module eeprom_rsp
  import eeprom_pkg::*;
#(
  parameter int         AW       = 11,
  parameter logic [3:0] DEV_ID   = DEV_ID_DEF,
  parameter bit         ACK_EN   = 1'b1,
  parameter logic [7:0] INIT_VAL = 8'hFF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SCL,
  inout  wire           SDA,
  output logic          BUSY,
  output logic          WR_PULSE,
  output logic [AW-1:0] LAST_ADDR
);

  localparam logic [AW-1:0] PTR_ONE = 'd1;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_cnt;
  logic [7:0]      r_shift;
  logic [AW-1:0]   r_ptr;
  logic            r_oe;
  logic            r_ack_ph;
  logic            r_rw;
  logic [7:0]      r_mem [2**AW];

  logic            w_sda;
  logic            w_rise;
  logic            w_fall;
  logic            w_start;
  logic            w_stop;
  logic [7:0]      w_byte;
  logic            w_last;
  logic            w_match;

  eeprom_line_sync u_sync (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_scl   (SCL),
    .i_sda   (SDA),
    .o_sda   (w_sda),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_start (w_start),
    .o_stop  (w_stop)
  );

  assign SDA  = r_oe ? ACK_LVL : 1'bz;
  assign BUSY = (r_state != S_IDLE);

  always_comb begin
    w_byte  = {r_shift[6:0], w_sda};
    w_last  = w_rise && (r_cnt == 3'd7);
    w_match = (w_byte[7:4] == DEV_ID);
    w_next  = r_state;
    if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_start) begin
      w_next = S_CTRL;
    end else begin
      unique case (r_state)
        S_CTRL:
          if (w_last) begin
            if (!w_match)          w_next = S_WAIT_STOP;
            else if (ACK_EN)       w_next = S_ACK_CTRL;
            else if (w_byte[RW_BIT]) w_next = S_RDATA;
            else                   w_next = S_ADDR;
          end
        S_ACK_CTRL:
          if (w_fall && r_ack_ph)
            w_next = r_rw ? S_RDATA : S_ADDR;
        S_ADDR:
          if (w_last)
            w_next = ACK_EN ? S_ACK_ADDR : S_WDATA;
        S_ACK_ADDR, S_ACK_WDATA:
          if (w_fall && r_ack_ph) w_next = S_WDATA;
        S_WDATA:
          if (w_last)
            w_next = ACK_EN ? S_ACK_WDATA : S_WDATA;
        S_RDATA:
          if (w_last)
            w_next = ACK_EN ? S_RACK : S_WAIT_STOP;
        S_RACK:
          if (w_rise)
            w_next = (w_sda == NACK_LVL) ? S_WAIT_STOP
                                         : S_RDATA;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt     <= 3'd0;
      r_shift   <= 8'd0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_ack_ph  <= 1'b0;
      r_rw      <= 1'b0;
      WR_PULSE  <= 1'b0;
      LAST_ADDR <= '0;
      for (int i = 0; i < 2**AW; i++)
        r_mem[i] <= INIT_VAL;
    end else begin
      WR_PULSE <= 1'b0;
      if (w_stop || w_start) begin
        r_oe     <= 1'b0;
        r_cnt    <= 3'd0;
        r_ack_ph <= 1'b0;
      end else begin
        unique case (r_state)
          S_CTRL:
            if (w_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 3'd1;
              if (w_last && w_match) begin
                r_rw <= w_byte[RW_BIT];
                if (w_byte[RW_BIT])
                  r_shift <= r_mem[r_ptr];
                else
                  r_ptr[AW-1:8] <= w_byte[AW-8:1];
              end
            end
          S_ADDR:
            if (w_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 3'd1;
              if (w_last) r_ptr[7:0] <= w_byte;
            end
          S_WDATA:
            if (w_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 3'd1;
              if (w_last) begin
                r_mem[r_ptr] <= w_byte;
                WR_PULSE     <= 1'b1;
                LAST_ADDR    <= r_ptr;
                r_ptr        <= r_ptr + PTR_ONE;
              end
            end
          // first fall starts the ACK, second ends it
          S_ACK_CTRL, S_ACK_ADDR, S_ACK_WDATA:
            if (w_fall) begin
              if (!r_ack_ph) begin
                r_oe     <= 1'b1;
                r_ack_ph <= 1'b1;
              end else begin
                r_ack_ph <= 1'b0;
                r_oe     <= 1'b0;
                if (r_state == S_ACK_CTRL && r_rw) begin
                  r_shift <= r_mem[r_ptr];
                  r_oe    <= ~r_mem[r_ptr][7];
                end
              end
            end
          S_RDATA:
            if (w_fall) begin
              r_oe <= ~r_shift[7];
            end else if (w_rise) begin
              r_shift <= {r_shift[6:0], 1'b0};
              r_cnt   <= r_cnt + 3'd1;
              if (w_last) begin
                LAST_ADDR <= r_ptr;
                r_ptr     <= r_ptr + PTR_ONE;
              end
            end
          S_RACK: begin
            if (w_fall) r_oe <= 1'b0;
            if (w_rise && w_sda == ACK_LVL) begin
              r_shift <= r_mem[r_ptr];
              r_cnt   <= 3'd0;
            end
          end
          default:
            if (w_fall || r_state == S_IDLE)
              r_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_rsp.sv
// tb_eeprom_rsp: bus-level master driving two responders
// (with and without ACK slots) against a memory model.
module tb_eeprom_rsp;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_a = 1'b1, scl_b = 1'b1;
  logic        mlo_a = 1'b0, mlo_b = 1'b0;
  wire         sda_a, sda_b;
  logic        busy_a, busy_b, wp_a, wp_b;
  logic [10:0] la_a, la_b;

  assign sda_a = mlo_a ? 1'b0 : 1'bz;
  assign sda_b = mlo_b ? 1'b0 : 1'bz;
  pullup (sda_a);
  pullup (sda_b);

  always #5 clk = ~clk;

  eeprom_rsp #(.AW(11), .DEV_ID(4'b1010), .ACK_EN(1'b1),
               .INIT_VAL(8'hFF)) u_a (
    .CLK(clk), .RESET(rst), .SCL(scl_a), .SDA(sda_a),
    .BUSY(busy_a), .WR_PULSE(wp_a), .LAST_ADDR(la_a));

  eeprom_rsp #(.AW(11), .DEV_ID(4'b1010), .ACK_EN(1'b0),
               .INIT_VAL(8'hFF)) u_b (
    .CLK(clk), .RESET(rst), .SCL(scl_b), .SDA(sda_b),
    .BUSY(busy_b), .WR_PULSE(wp_b), .LAST_ADDR(la_b));

  int checks = 0;
  int failures = 0;
  int wcnt_a = 0, wcnt_b = 0;
  int low_a = 0, low_b = 0;
  logic [7:0] mem_m [2][2048];
  int         ptr_m [2];

  always @(negedge clk) begin
    if (wp_a === 1'b1) wcnt_a++;
    if (wp_b === 1'b1) wcnt_b++;
  end

  always @(posedge clk) begin
    if (sda_a === 1'b0 && !mlo_a) low_a++;
    if (sda_b === 1'b0 && !mlo_b) low_b++;
  end

  initial begin
    #1500us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 2048; i++) mem_m[b][i] = 8'hFF;
      ptr_m[b] = 0;
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic drv_scl(input int b, input logic v);
    if (b == 0) scl_a = v;
    else        scl_b = v;
  endtask

  task automatic drv_sda(input int b, input logic v);
    if (b == 0) mlo_a = ~v;
    else        mlo_b = ~v;
  endtask

  task automatic bus_start(input int b);
    drv_sda(b, 1'b1); wq();
    drv_scl(b, 1'b1); wq();
    drv_sda(b, 1'b0); wq();
    drv_scl(b, 1'b0); wq();
  endtask

  task automatic bus_stop(input int b);
    drv_sda(b, 1'b0); wq();
    drv_scl(b, 1'b1); wq();
    drv_sda(b, 1'b1); wq(); wq();
  endtask

  task automatic wr_bit(input int b, input logic v);
    drv_sda(b, v); wq();
    drv_scl(b, 1'b1); wq(); wq();
    drv_scl(b, 1'b0); wq();
  endtask

  task automatic rd_bit(input int b, output logic v);
    drv_sda(b, 1'b1); wq();
    drv_scl(b, 1'b1); wq();
    v = (b == 0) ? sda_a : sda_b;
    wq();
    drv_scl(b, 1'b0); wq();
  endtask

  task automatic wr_byte(input int b, input logic [7:0] d,
                         output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(b, d[i]);
    if (b == 0) rd_bit(b, ack);
    else        ack = 1'b0;
  endtask

  task automatic rd_byte(input int b, input logic nack,
                         output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b, v);
      d[i] = v;
    end
    if (b == 0) wr_bit(b, nack);
  endtask

  task automatic test_reset();
    logic ack;
    logic [7:0] d;
    checks++;
    if ({busy_a, wp_a, la_a, sda_a} !== 14'h0001) begin
      failures++;
      $display("FAIL reset_a act=%b/%b/%h/%b exp=0/0/000/1",
               busy_a, wp_a, la_a, sda_a);
    end
    checks++;
    if ({busy_b, wp_b, la_b, sda_b} !== 14'h0001) begin
      failures++;
      $display("FAIL reset_b act=%b/%b/%h/%b exp=0/0/000/1",
               busy_b, wp_b, la_b, sda_b);
    end
    bus_start(0);
    wr_byte(0, 8'hA1, ack);
    rd_byte(0, 1'b1, d);
    bus_stop(0);
    checks++;
    if ({ack, d} !== {1'b0, mem_m[0][ptr_m[0]]}) begin
      failures++;
      $display("FAIL reset_read act=%b/%h exp=0/%h",
               ack, d, mem_m[0][ptr_m[0]]);
    end
    checks++;
    if (la_a !== 11'(ptr_m[0])) begin
      failures++;
      $display("FAIL reset_read_la act=%h exp=%h", la_a, ptr_m[0]);
    end
    ptr_m[0] = (ptr_m[0] + 1) % 2048;
  endtask

  task automatic test_write();
    logic [2:0] acks;
    logic a;
    int w0;
    w0 = wcnt_a;
    bus_start(0);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL write_busy act=%b exp=1", busy_a);
    end
    wr_byte(0, 8'hA4, a); acks[2] = a;
    wr_byte(0, 8'h3C, a); acks[1] = a;
    wr_byte(0, 8'h5A, a); acks[0] = a;
    bus_stop(0);
    mem_m[0][11'h23C] = 8'h5A;
    ptr_m[0] = 11'h23D;
    checks++;
    if (acks !== 3'b000) begin
      failures++;
      $display("FAIL write_acks act=%b exp=000", acks);
    end
    checks++;
    if (wcnt_a - w0 != 1) begin
      failures++;
      $display("FAIL write_pulses act=%0d exp=1", wcnt_a - w0);
    end
    checks++;
    if ({busy_a, la_a} !== {1'b0, 11'h23C}) begin
      failures++;
      $display("FAIL write_end act=%b/%h exp=0/23c", busy_a, la_a);
    end
  endtask

  task automatic test_random_read();
    logic [3:0] acks;
    logic a;
    logic [7:0] d;
    bus_start(0);
    wr_byte(0, 8'hA4, a); acks[3] = a;
    wr_byte(0, 8'h3C, a); acks[2] = a;
    bus_start(0);
    wr_byte(0, 8'hA5, a); acks[1] = a;
    rd_byte(0, 1'b1, d);
    acks[0] = 1'b0;
    bus_stop(0);
    checks++;
    if ({acks, d} !== {4'b0000, 8'h5A}) begin
      failures++;
      $display("FAIL rand_read act=%b/%h exp=0000/5a", acks, d);
    end
    checks++;
    if ({busy_a, la_a} !== {1'b0, 11'h23C}) begin
      failures++;
      $display("FAIL rand_read_end act=%b/%h exp=0/23c",
               busy_a, la_a);
    end
    ptr_m[0] = 11'h23D;
  endtask

  task automatic test_wrap();
    logic a, acc;
    logic [7:0] d0, d1;
    int w0;
    acc = 1'b0;
    w0 = wcnt_a;
    bus_start(0);
    wr_byte(0, 8'hAE, a); acc |= a;
    wr_byte(0, 8'hFF, a); acc |= a;
    wr_byte(0, 8'h11, a); acc |= a;
    wr_byte(0, 8'h22, a); acc |= a;
    bus_stop(0);
    mem_m[0][11'h7FF] = 8'h11;
    mem_m[0][11'h000] = 8'h22;
    checks++;
    if ({acc, la_a} !== {1'b0, 11'h000} || wcnt_a - w0 != 2) begin
      failures++;
      $display("FAIL wrap_write act=%b/%h/%0d exp=0/000/2",
               acc, la_a, wcnt_a - w0);
    end
    bus_start(0);
    wr_byte(0, 8'hAE, a); acc |= a;
    wr_byte(0, 8'hFF, a); acc |= a;
    bus_start(0);
    wr_byte(0, 8'hAF, a); acc |= a;
    rd_byte(0, 1'b0, d0);
    rd_byte(0, 1'b1, d1);
    bus_stop(0);
    checks++;
    if ({acc, d0, d1} !== {1'b0, mem_m[0][11'h7FF],
                           mem_m[0][11'h000]}) begin
      failures++;
      $display("FAIL wrap_read act=%b/%h/%h exp=0/11/22",
               acc, d0, d1);
    end
    checks++;
    if (la_a !== 11'h000) begin
      failures++;
      $display("FAIL wrap_read_la act=%h exp=000", la_a);
    end
    ptr_m[0] = 1;
  endtask

  task automatic test_wrong_dev();
    logic a;
    int w0, l0;
    w0 = wcnt_a;
    l0 = low_a;
    bus_start(0);
    wr_byte(0, 8'hB0, a);
    for (int i = 0; i < 16; i++) wr_bit(0, 1'b1);
    checks++;
    if (a !== 1'b1) begin
      failures++;
      $display("FAIL wrongdev_nack act=%b exp=1", a);
    end
    checks++;
    if (busy_a !== 1'b1 || low_a != l0 || wcnt_a != w0) begin
      failures++;
      $display("FAIL wrongdev_bus act=%b/%0d/%0d exp=1/0/0",
               busy_a, low_a - l0, wcnt_a - w0);
    end
    bus_stop(0);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL wrongdev_stop act=%b exp=0", busy_a);
    end
  endtask

  task automatic test_random();
    logic [10:0] a;
    logic [7:0]  d, r;
    logic        ack, acc;
    int          n, w0;
    for (int it = 0; it < 5; it++) begin
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 4);
      if (it == 0) begin
        a = 11'h7FE;
        n = 4;
      end
      acc = 1'b0;
      w0 = wcnt_a;
      bus_start(0);
      wr_byte(0, {4'hA, a[10:8], 1'b0}, ack); acc |= ack;
      wr_byte(0, a[7:0], ack); acc |= ack;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        wr_byte(0, d, ack); acc |= ack;
        mem_m[0][11'(a + k)] = d;
      end
      bus_stop(0);
      ptr_m[0] = (a + n) % 2048;
      checks++;
      if (acc !== 1'b0 || wcnt_a - w0 != n) begin
        failures++;
        $display("FAIL rnd_write it=%0d act=%b/%0d exp=0/%0d",
                 it, acc, wcnt_a - w0, n);
      end
      checks++;
      if (la_a !== 11'(a + n - 1)) begin
        failures++;
        $display("FAIL rnd_write_la it=%0d act=%h exp=%h",
                 it, la_a, 11'(a + n - 1));
      end
      bus_start(0);
      wr_byte(0, {4'hA, a[10:8], 1'b0}, ack);
      wr_byte(0, a[7:0], ack);
      bus_start(0);
      wr_byte(0, {4'hA, a[10:8], 1'b1}, ack);
      for (int k = 0; k < n; k++) begin
        rd_byte(0, (k == n - 1), r);
        checks++;
        if (r !== mem_m[0][11'(a + k)]) begin
          failures++;
          $display("FAIL rnd_read it=%0d k=%0d act=%h exp=%h",
                   it, k, r, mem_m[0][11'(a + k)]);
        end
      end
      bus_stop(0);
      checks++;
      if (la_a !== 11'(a + n - 1)) begin
        failures++;
        $display("FAIL rnd_read_la it=%0d act=%h exp=%h",
                 it, la_a, 11'(a + n - 1));
      end
    end
  endtask

  task automatic test_abort();
    logic a;
    logic [7:0] d;
    int w0;
    w0 = wcnt_a;
    bus_start(0);
    wr_byte(0, 8'hA2, a);
    wr_byte(0, 8'h23, a);
    wr_bit(0, 1'b1); wr_bit(0, 1'b0);
    wr_bit(0, 1'b1); wr_bit(0, 1'b0);
    bus_stop(0);
    checks++;
    if (busy_a !== 1'b0 || wcnt_a != w0) begin
      failures++;
      $display("FAIL abort_stop act=%b/%0d exp=0/0",
               busy_a, wcnt_a - w0);
    end
    bus_start(0);
    wr_byte(0, 8'hA2, a);
    wr_byte(0, 8'h23, a);
    bus_start(0);
    wr_byte(0, 8'hA3, a);
    rd_byte(0, 1'b1, d);
    bus_stop(0);
    checks++;
    if (d !== mem_m[0][11'h123]) begin
      failures++;
      $display("FAIL abort_mem act=%h exp=%h", d, mem_m[0][11'h123]);
    end
    bus_start(0);
    wr_bit(0, 1'b1); wr_bit(0, 1'b0);
    wr_bit(0, 1'b1); wr_bit(0, 1'b0);
    drv_sda(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_a, wp_a, la_a, sda_a} !== 14'h0001) begin
      failures++;
      $display("FAIL abort_reset act=%b/%b/%h/%b exp=0/0/000/1",
               busy_a, wp_a, la_a, sda_a);
    end
    rst = 1'b0;
    drv_scl(0, 1'b1);
    wq();
    model_reset();
    bus_start(0);
    wr_byte(0, 8'hA4, a);
    wr_byte(0, 8'h3C, a);
    bus_start(0);
    wr_byte(0, 8'hA5, a);
    rd_byte(0, 1'b1, d);
    bus_stop(0);
    checks++;
    if ({d, la_a} !== {mem_m[0][11'h23C], 11'h23C}) begin
      failures++;
      $display("FAIL abort_reinit act=%h/%h exp=ff/23c", d, la_a);
    end
  endtask

  task automatic test_no_ack();
    logic a;
    logic [7:0] d;
    int w0, l0;
    w0 = wcnt_b;
    l0 = low_b;
    bus_start(1);
    wr_byte(1, 8'hA0, a);
    wr_byte(1, 8'h01, a);
    wr_byte(1, 8'hC3, a);
    bus_stop(1);
    mem_m[1][11'h001] = 8'hC3;
    checks++;
    if (low_b != l0 || wcnt_b - w0 != 1) begin
      failures++;
      $display("FAIL noack_write act=%0d/%0d exp=0/1",
               low_b - l0, wcnt_b - w0);
    end
    checks++;
    if ({busy_b, la_b} !== {1'b0, 11'h001}) begin
      failures++;
      $display("FAIL noack_write_end act=%b/%h exp=0/001",
               busy_b, la_b);
    end
    bus_start(1);
    wr_byte(1, 8'hA0, a);
    wr_byte(1, 8'h01, a);
    bus_start(1);
    wr_byte(1, 8'hA1, a);
    rd_byte(1, 1'b1, d);
    bus_stop(1);
    checks++;
    if ({d, la_b, busy_b} !== {mem_m[1][11'h001], 11'h001, 1'b0}) begin
      failures++;
      $display("FAIL noack_read act=%h/%h/%b exp=c3/001/0",
               d, la_b, busy_b);
    end
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_write();
    test_random_read();
    test_wrap();
    test_wrong_dev();
    test_random();
    test_abort();
    test_no_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
